wb_stage_cp0: RTL

//  Write-back stage with an integrated CP0 subset: Status, Cause, EPC, BadVAddr, Count and Compare.

---
 rtl/wb_stage_cp0.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/wb_stage_cp0.sv
// Write-back stage with a small CP0 (Status, Cause, EPC, BadVAddr, Count,
// Compare). It commits GPR results and takes exceptions, interrupts and eret.
// Any of those produces a one-cycle flush with a redirect PC.
module wb_stage_cp0 #(
    parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
    parameter int          COUNT_DIV = 2,
    parameter int          HW_INT_W  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ms_to_ws_valid,
    output logic                ws_allowin,
    input  logic [31:0]         ms_pc,
    input  logic                ms_gr_we,
    input  logic [4:0]          ms_dest,
    input  logic [31:0]         ms_result,
    input  logic [31:0]         ms_rt_value,
    input  logic                ms_mfc0,
    input  logic                ms_mtc0,
    input  logic                ms_eret,
    input  logic [4:0]          ms_cp0_addr,
    input  logic                ms_ex,
    input  logic [4:0]          ms_excode,
    input  logic                ms_bd,
    input  logic [31:0]         ms_badvaddr,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                ws_flush,
    output logic [31:0]         ws_flush_pc,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

    localparam logic [4:0] A_BADV = 5'd8,  A_COUNT = 5'd9,  A_CMP = 5'd11;
    localparam logic [4:0] A_STAT = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;

    // WB payload
    logic        r_ws_valid;
    logic [31:0] r_pc, r_result, r_rt_value, r_badvaddr;
    logic        r_gr_we, r_mfc0, r_mtc0, r_eret, r_ex, r_bd;
    logic [4:0]  r_dest, r_cp0_addr, r_excode;

    // CP0 state
    logic [7:0]  r_c0_im;
    logic        r_c0_exl, r_c0_ie;
    logic        r_c0_bd, r_c0_ti;
    logic [5:0]  r_c0_ip_hw;
    logic [1:0]  r_c0_ip_sw;
    logic [4:0]  r_c0_excode;
    logic [31:0] r_c0_epc, r_c0_badv, r_c0_count, r_c0_cmp;
    logic        r_c0_cmp_set;
    logic [DIV_W-1:0] r_div;

    logic        w_ready_go, w_int, w_exc, w_eret, w_mtc0;
    logic [4:0]  w_exc_code;
    logic [5:0]  w_hw_ext;
    logic [31:0] w_status, w_cause, w_cp0_rdata;

    assign w_ready_go = 1'b1;
    assign ws_allowin = !r_ws_valid || w_ready_go;

    assign w_status = {9'd0, 1'b1, 6'd0, r_c0_im, 6'd0, r_c0_exl, r_c0_ie};
    assign w_cause  = {r_c0_bd, r_c0_ti, 14'd0, r_c0_ip_hw, r_c0_ip_sw, 1'b0, r_c0_excode, 2'b00};

    // Interrupt is only taken against a valid WB instruction; it outranks an
    // upstream exception on the same instruction.
    assign w_int      = r_ws_valid && r_c0_ie && !r_c0_exl &&
                        (|({r_c0_ip_hw, r_c0_ip_sw} & r_c0_im));
    assign w_exc      = (r_ws_valid && r_ex) || w_int;
    assign w_exc_code = w_int ? 5'd0 : r_excode;
    assign w_eret     = r_ws_valid && r_eret && !w_exc;
    assign w_mtc0     = r_ws_valid && r_mtc0 && !w_exc;

    assign ws_flush    = w_exc || w_eret;
    assign ws_flush_pc = w_exc ? EX_ENTRY : (w_eret ? r_c0_epc : 32'd0);

    assign rf_we    = r_ws_valid && r_gr_we && !w_exc;
    assign rf_waddr = r_dest;
    assign rf_wdata = r_mfc0 ? w_cp0_rdata : r_result;

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // Zero-extend the external interrupt lines onto IP[7:2]
    always_comb begin
        w_hw_ext = 6'd0;
        w_hw_ext[HW_INT_W-1:0] = hw_int;
    end

    // CP0 read port, sees state before this cycle's write
    always_comb begin
        w_cp0_rdata = 32'd0;
        case (r_cp0_addr)
            A_BADV:  w_cp0_rdata = r_c0_badv;
            A_COUNT: w_cp0_rdata = r_c0_count;
            A_CMP:   w_cp0_rdata = r_c0_cmp;
            A_STAT:  w_cp0_rdata = w_status;
            A_CAUSE: w_cp0_rdata = w_cause;
            A_EPC:   w_cp0_rdata = r_c0_epc;
            default: w_cp0_rdata = 32'd0;
        endcase
    end

    // Valid bit: an instruction arriving during a flush is dropped
    always_ff @(posedge clk) begin
        if (!resetn)         r_ws_valid <= 1'b0;
        else if (ws_allowin) r_ws_valid <= ms_to_ws_valid && !ws_flush;
    end

    // Payload capture on handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc <= '0; r_result <= '0; r_rt_value <= '0; r_badvaddr <= '0;
            r_gr_we <= 1'b0; r_mfc0 <= 1'b0; r_mtc0 <= 1'b0; r_eret <= 1'b0;
            r_ex <= 1'b0; r_bd <= 1'b0;
            r_dest <= '0; r_cp0_addr <= '0; r_excode <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_pc <= ms_pc; r_result <= ms_result; r_rt_value <= ms_rt_value;
            r_badvaddr <= ms_badvaddr;
            r_gr_we <= ms_gr_we; r_mfc0 <= ms_mfc0; r_mtc0 <= ms_mtc0;
            r_eret <= ms_eret; r_ex <= ms_ex; r_bd <= ms_bd;
            r_dest <= ms_dest; r_cp0_addr <= ms_cp0_addr; r_excode <= ms_excode;
        end
    end

    // CP0 update: timer, exception/eret commit, mtc0 writes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_c0_im <= '0; r_c0_exl <= 1'b0; r_c0_ie <= 1'b0;
            r_c0_bd <= 1'b0; r_c0_ti <= 1'b0; r_c0_ip_hw <= '0; r_c0_ip_sw <= '0;
            r_c0_excode <= '0; r_c0_epc <= '0; r_c0_badv <= '0;
            r_c0_count <= '0; r_c0_cmp <= '0; r_c0_cmp_set <= 1'b0; r_div <= '0;
        end else begin
            r_c0_ip_hw <= w_hw_ext | {r_c0_ti, 5'd0};

            if (w_mtc0 && r_cp0_addr == A_COUNT) begin
                r_c0_count <= r_rt_value;
                r_div      <= '0;
            end else if (r_div == DIV_MAX) begin
                r_c0_count <= r_c0_count + 32'd1;
                r_div      <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_mtc0 && r_cp0_addr == A_CMP) begin
                r_c0_cmp     <= r_rt_value;
                r_c0_cmp_set <= 1'b1;
                r_c0_ti      <= 1'b0;
            end else if (r_c0_cmp_set && r_c0_count == r_c0_cmp) begin
                r_c0_ti <= 1'b1;
            end

            if (w_exc) begin
                if (!r_c0_exl) begin
                    r_c0_epc <= r_bd ? r_pc - 32'd4 : r_pc;
                    r_c0_bd  <= r_bd;
                end
                r_c0_exl    <= 1'b1;
                r_c0_excode <= w_exc_code;
                if (w_exc_code == 5'd4 || w_exc_code == 5'd5) r_c0_badv <= r_badvaddr;
            end else if (w_eret) begin
                r_c0_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (r_cp0_addr)
                    A_STAT: begin
                        r_c0_im  <= r_rt_value[15:8];
                        r_c0_exl <= r_rt_value[1];
                        r_c0_ie  <= r_rt_value[0];
                    end
                    A_CAUSE: r_c0_ip_sw <= r_rt_value[9:8];
                    A_EPC:   r_c0_epc   <= r_rt_value;
                    default: ;
                endcase
            end
        end
    end
endmodule
